// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs an 8-bit AXI-Stream byte stream into DATA_WIDTH-bit words with per-lane
// strobes and tlast, and reports packet byte lengths. Define PACKER_BIG_ENDIAN_EN for big-endian lane order.
module axis_byte_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    s01_axis_aclk,
   input  logic                    s01_axis_aresetn,
   input  logic [7:0]              s01_axis_tdata,
   input  logic                    s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   input  logic                    m01_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_wr_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   output logic                    pkt_done,
   output logic [LEN_WIDTH-1:0]    pkt_len
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDXW  = $clog2(BYTES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

   typedef enum logic {IDLE, FILL} state_e;

   state_e                 state_q;
   logic [IDXW-1:0]        idx_q;
   logic [DATA_WIDTH-1:0]  acc_q;
   logic [BYTES-1:0]       strbAcc_q;
   logic [LEN_WIDTH-1:0]   cnt_q;
   logic [LEN_WIDTH-1:0]   pendLen_q;
   logic [DATA_WIDTH-1:0]  mData_q;
   logic [BYTES-1:0]       mStrb_q;
   logic                   mValid_q;
   logic                   mLast_q;
   logic                   pktDone_q;
   logic [LEN_WIDTH-1:0]   pktLen_q;

   logic [IDXW-1:0]        laneSel;
   logic [DATA_WIDTH-1:0]  byteWord;
   logic [BYTES-1:0]       byteStrb;
   logic [DATA_WIDTH-1:0]  acc_d;
   logic [BYTES-1:0]       strbAcc_d;
   logic [LEN_WIDTH-1:0]   cnt_d;
   logic                   accept;
   logic                   closeWord;

   assign s01_axis_tready = ~mValid_q | m01_axis_tready;

   always_comb begin
`ifdef PACKER_BIG_ENDIAN_EN
      laneSel = LAST_IDX - idx_q;
`else
      laneSel = idx_q;
`endif
      byteWord = '0;
      byteWord[8*laneSel +: 8] = s01_axis_tdata;
      byteStrb = '0;
      byteStrb[laneSel] = 1'b1;
      acc_d     = s01_axis_tstrb ? (acc_q | byteWord) : acc_q;
      strbAcc_d = s01_axis_tstrb ? (strbAcc_q | byteStrb) : strbAcc_q;
      // Length saturates instead of wrapping so oversized packets still report a sane maximum.
      cnt_d = (s01_axis_tstrb && (cnt_q != '1)) ? cnt_q + LEN_WIDTH'(1) : cnt_q;
      accept    = s01_axis_tvalid & s01_axis_tready;
      closeWord = accept & ((s01_axis_tstrb & (idx_q == LAST_IDX)) | s01_axis_tlast);
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         strbAcc_q <= '0;
         cnt_q     <= '0;
         pendLen_q <= '0;
         mData_q   <= '0;
         mStrb_q   <= '0;
         mValid_q  <= 1'b0;
         mLast_q   <= 1'b0;
         pktDone_q <= 1'b0;
         pktLen_q  <= '0;
      end else begin
         pktDone_q <= 1'b0;
         if (mValid_q && m01_axis_tready) begin
            mValid_q <= 1'b0;
            if (mLast_q) begin
               pktDone_q <= 1'b1;
               pktLen_q  <= pendLen_q;
            end
         end
         // A closing byte may load a new word on the same edge the previous one drains.
         if (accept) begin
            if (closeWord) begin
               mData_q   <= acc_d;
               mStrb_q   <= strbAcc_d;
               mValid_q  <= 1'b1;
               mLast_q   <= s01_axis_tlast;
               acc_q     <= '0;
               strbAcc_q <= '0;
               idx_q     <= '0;
               if (s01_axis_tlast) begin
                  pendLen_q <= cnt_d;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q   <= cnt_d;
                  state_q <= FILL;
               end
            end else if (s01_axis_tstrb) begin
               acc_q     <= acc_d;
               strbAcc_q <= strbAcc_d;
               idx_q     <= idx_q + IDXW'(1);
               cnt_q     <= cnt_d;
               if (state_q == IDLE) begin
                  state_q <= FILL;
               end
            end
         end
      end
   end

   assign m01_axis_wr_tdata = mData_q;
   assign m01_axis_tstrb    = mStrb_q;
   assign m01_axis_tvalid   = mValid_q;
   assign m01_axis_tlast    = mLast_q;
   assign pkt_done          = pktDone_q;
   assign pkt_len           = pktLen_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer: directed and random byte streams checked against a byte-list packet model.
`timescale 1ns/1ps
module tb_axis_byte_packer;

   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 16;
   localparam int BYTES      = DATA_WIDTH / 8;

   typedef struct packed { logic [7:0] data; logic strb; logic last; } beat_t;
   typedef struct packed { logic [DATA_WIDTH-1:0] data; logic [BYTES-1:0] strb; logic last; } word_t;

   logic                  clk = 1'b0;
   logic                  rstN = 1'b0;
   logic [7:0]            sData = 8'h00;
   logic                  sStrb = 1'b0;
   logic                  sValid = 1'b0;
   logic                  sLast = 1'b0;
   logic                  sReady;
   logic                  mReady;
   logic [DATA_WIDTH-1:0] mData;
   logic [BYTES-1:0]      mStrb;
   logic                  mValid;
   logic                  mLast;
   logic                  pktDone;
   logic [LEN_WIDTH-1:0]  pktLen;

   int checkCount = 0;
   int failCount  = 0;
   int cycle      = 0;

   int   readyMode   = 0;
   logic manualReady = 1'b1;
   logic randReady   = 1'b1;

   word_t      gotW[$];
   int         gotCyc[$];
   int         gotLen[$];
   word_t      expW[$];
   int         expLen[$];
   logic [7:0] curBytes[$];
   int         curCount = 0;

   axis_byte_packer #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
      .s01_axis_aclk     (clk),
      .s01_axis_aresetn  (rstN),
      .s01_axis_tdata    (sData),
      .s01_axis_tstrb    (sStrb),
      .s01_axis_tvalid   (sValid),
      .s01_axis_tlast    (sLast),
      .s01_axis_tready   (sReady),
      .m01_axis_tready   (mReady),
      .m01_axis_wr_tdata (mData),
      .m01_axis_tstrb    (mStrb),
      .m01_axis_tvalid   (mValid),
      .m01_axis_tlast    (mLast),
      .pkt_done          (pktDone),
      .pkt_len           (pktLen)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle++;
      #1;
      randReady = 1'($urandom_range(0, 1));
   end

   assign mReady = (readyMode == 1) ? randReady : manualReady;

   // Record every word and length report at the negedge before the edge that consumes it.
   always @(negedge clk) begin
      if (rstN && mValid && mReady) begin
         gotW.push_back(word_t'({mData, mStrb, mLast}));
         gotCyc.push_back(cycle);
      end
      if (rstN && pktDone) gotLen.push_back(int'(pktLen));
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Packet model: collect valid bytes, emit a word when BYTES are held or tlast arrives.
   function automatic void modelBeat(beat_t b);
      word_t w;
      if (b.strb) begin
         curBytes.push_back(b.data);
         if (curCount < (1 << LEN_WIDTH) - 1) curCount++;
      end
      if (b.last || curBytes.size() == BYTES) begin
         w = '0;
         foreach (curBytes[k]) begin
`ifdef PACKER_BIG_ENDIAN_EN
            w.data[8*(BYTES-1-k) +: 8] = curBytes[k];
            w.strb[BYTES-1-k] = 1'b1;
`else
            w.data[8*k +: 8] = curBytes[k];
            w.strb[k] = 1'b1;
`endif
         end
         w.last = b.last;
         expW.push_back(w);
         curBytes.delete();
         if (b.last) begin
            expLen.push_back(curCount);
            curCount = 0;
         end
      end
   endfunction

   function automatic void clearAll();
      gotW.delete(); gotCyc.delete(); gotLen.delete();
      expW.delete(); expLen.delete(); curBytes.delete();
      curCount = 0;
   endfunction

   task automatic sendBeat(input logic [7:0] d, input logic s, input logic l, input int maxGap);
      bit ok;
      beat_t b;
      repeat ($urandom_range(0, maxGap)) begin
         @(posedge clk); #1;
      end
      sData = d; sStrb = s; sLast = l; sValid = 1'b1;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = sReady;
         @(posedge clk); #1;
      end
      sValid = 1'b0;
      if (!ok) begin
         checkCount++; failCount++;
         $display("[TB] FAIL sendBeat: byte %h not accepted within 200 cycles", d);
      end
      b = '{data: d, strb: s, last: l};
      modelBeat(b);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((gotW.size() < expW.size() || gotLen.size() < expLen.size()) && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 400) begin
         checkCount++; failCount++;
         $display("[TB] FAIL drain: got %0d words / %0d lengths, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      repeat (6) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tvalid: got %b expected 0", mValid); end
      checkCount++;
      if (mLast !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tlast: got %b expected 0", mLast); end
      checkCount++;
      if (mData !== '0) begin failCount++; $display("[TB] FAIL reset_tdata: got %h expected 0", mData); end
      checkCount++;
      if (mStrb !== '0) begin failCount++; $display("[TB] FAIL reset_tstrb: got %h expected 0", mStrb); end
      checkCount++;
      if (pktDone !== 1'b0) begin failCount++; $display("[TB] FAIL reset_pkt_done: got %b expected 0", pktDone); end
      checkCount++;
      if (pktLen !== '0) begin failCount++; $display("[TB] FAIL reset_pkt_len: got %0d expected 0", pktLen); end
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_words();
      readyMode = 0; manualReady = 1'b1;
      for (int i = 1; i <= 8; i++) sendBeat(8'(i * 8'h11), 1'b1, i == 8, 0);
      drain();
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL full_words_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL full_words_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL full_words_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
   endtask

   task automatic test_partial_word();
      for (int i = 1; i <= 6; i++) sendBeat(8'hA0 + 8'(i), 1'b1, i == 6, 1);
      drain();
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL partial_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL partial_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL partial_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
   endtask

   task automatic test_null_bytes();
      sendBeat(8'h01, 1'b1, 1'b0, 0);
      sendBeat(8'h02, 1'b0, 1'b0, 0);
      sendBeat(8'h03, 1'b1, 1'b0, 0);
      sendBeat(8'h04, 1'b1, 1'b0, 0);
      sendBeat(8'h05, 1'b1, 1'b1, 0);
      // Full word followed by a null tlast: boundary-only word with empty strobes.
      for (int i = 1; i <= 4; i++) sendBeat(8'hD0 + 8'(i), 1'b1, 1'b0, 0);
      sendBeat(8'hEE, 1'b0, 1'b1, 0);
      drain();
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL null_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL null_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL null_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
   endtask

   task automatic test_back_to_back();
      int startCyc;
      readyMode = 0; manualReady = 1'b0;
      for (int i = 1; i <= 4; i++) sendBeat(8'hC0 + 8'(i), 1'b1, 1'b0, 0);
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         checkCount++;
         if (mValid !== 1'b1 || word_t'({mData, mStrb, mLast}) !== expW[0]) begin
            failCount++;
            $display("[TB] FAIL hold_word cycle %0d: got v=%b %h/%h/%b expected v=1 %h/%h/%b", h,
                     mValid, mData, mStrb, mLast, expW[0].data, expW[0].strb, expW[0].last);
         end
         checkCount++;
         if (sReady !== 1'b0) begin
            failCount++; $display("[TB] FAIL hold_s_tready cycle %0d: got %b expected 0", h, sReady);
         end
         @(posedge clk); #1;
      end
      manualReady = 1'b1;
      startCyc = cycle;
      for (int i = 1; i <= 12; i++) sendBeat(8'hE0 + 8'(i), 1'b1, i == 12, 0);
      checkCount++;
      if (cycle - startCyc != 12) begin
         failCount++; $display("[TB] FAIL stream_stall: 12 bytes took %0d cycles expected 12", cycle - startCyc);
      end
      drain();
      for (int i = 1; i < gotCyc.size(); i++) begin
         checkCount++;
         if (gotCyc[i] - gotCyc[i-1] != BYTES) begin
            failCount++;
            $display("[TB] FAIL word_spacing%0d: got %0d cycles expected %0d", i, gotCyc[i] - gotCyc[i-1], BYTES);
         end
      end
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL b2b_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL b2b_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL b2b_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
   endtask

   task automatic test_reset_mid_packet();
      manualReady = 1'b1;
      for (int i = 1; i <= 3; i++) sendBeat(8'h70 + 8'(i), 1'b1, 1'b0, 0);
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_tvalid: got %b expected 0", mValid); end
      clearAll();
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 4; i++) sendBeat(8'hB0 + 8'(i), 1'b1, i == 4, 0);
      drain();
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL midreset_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL midreset_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL midreset_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
   endtask

   task automatic test_random();
      int len;
      readyMode = 1;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 11);
         for (int i = 1; i <= len; i++)
            sendBeat(8'($urandom), ($urandom_range(0, 4) != 0), i == len, 2);
      end
      drain();
      checkCount++;
      if (gotW.size() != expW.size() || gotLen.size() != expLen.size()) begin
         failCount++;
         $display("[TB] FAIL random_count: got %0d words %0d lens, expected %0d / %0d",
                  gotW.size(), gotLen.size(), expW.size(), expLen.size());
      end
      for (int i = 0; i < expW.size() && i < gotW.size(); i++) begin
         checkCount++;
         if (gotW[i] !== expW[i]) begin
            failCount++;
            $display("[TB] FAIL random_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     gotW[i].data, gotW[i].strb, gotW[i].last, expW[i].data, expW[i].strb, expW[i].last);
         end
      end
      for (int i = 0; i < expLen.size() && i < gotLen.size(); i++) begin
         checkCount++;
         if (gotLen[i] != expLen[i]) begin
            failCount++; $display("[TB] FAIL random_len%0d: got %0d expected %0d", i, gotLen[i], expLen[i]);
         end
      end
      clearAll();
      readyMode = 0;
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_partial_word();
      test_null_bytes();
      test_back_to_back();
      test_reset_mid_packet();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
- Upstream stage of the AXI-Stream memory controller write port.
- Accepts an 8-bit AXI-Stream byte stream and packs consecutive bytes into DATA_WIDTH-bit words.
- Emits each packed word on a master AXI-Stream port with per-byte tstrb and tlast, ready to drive the controller's s01_axis_wr_tdata, s01_axis_tstrb, s01_axis_tvalid and s01_axis_tlast.
- Reports the byte length of each completed packet.

Parameters:
- DATA_WIDTH, 32, output word width; must be a multiple of 8 and at least 16. BYTES = DATA_WIDTH/8.
- LEN_WIDTH, 16, width of the packet byte-length counter and report.

Ports:
- s01_axis_aclk  input  1  single clock for both the slave and master sides.
- s01_axis_aresetn  input  1  asynchronous active-low reset.
- s01_axis_tdata  input  8  input byte.
- s01_axis_tstrb  input  1  1 = byte is valid data; 0 = null byte.
- s01_axis_tvalid  input  1  input byte valid.
- s01_axis_tlast  input  1  last byte of the packet.
- s01_axis_tready  output  1  packer can accept a byte.
- m01_axis_tready  input  1  downstream accepts a word.
- m01_axis_wr_tdata  output  DATA_WIDTH  packed word.
- m01_axis_tstrb  output  BYTES  per-lane valid flags.
- m01_axis_tvalid  output  1  word valid.
- m01_axis_tlast  output  1  word closes the packet.
- pkt_done  output  1  one-cycle pulse when a tlast word is accepted downstream.
- pkt_len  output  LEN_WIDTH  byte count of the last completed packet; held until the next pkt_done.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; lane index 0; accumulator and strobe accumulator 0; FSM to IDLE. Reset mid-packet discards the partial word and the pending output word; nothing partial is emitted after reset.
- Acceptance rule: s01_axis_tready = ~m01_axis_tvalid | m01_axis_tready. This is combinational from registered state and m01_axis_tready. A byte is accepted on a rising edge where s01_axis_tvalid & s01_axis_tready.
- Accepted byte with tstrb=1:
  - Data goes to lane idx: bits [8*idx+7 : 8*idx].
  - Strobe bit idx is set.
  - Running packet byte count increments.
- Accepted byte with tstrb=0: not stored; idx and count unchanged.
- Word close: on an accepted byte where (tstrb=1 and idx=BYTES-1) or tlast=1:
  - Next cycle m01_axis_tvalid=1.
  - m01_axis_wr_tdata and m01_axis_tstrb take the accumulator merged with the current byte.
  - m01_axis_tlast = s01_axis_tlast.
  - Accumulator, strobe accumulator and idx clear to 0.
- Latency: one cycle from the closing byte's acceptance to m01_axis_tvalid.
- Null tlast with an empty accumulator emits a word with tstrb=0 and tlast=1, so the packet boundary is preserved. An unused data lane is 0.
- Output hold: while m01_axis_tvalid=1 and m01_axis_tready=0, all m01 outputs are stable and s01_axis_tready=0.
- Simultaneous events: if the output word is accepted and a closing byte is accepted in the same cycle, the new word is loaded and tvalid stays 1 (full throughput: one word every BYTES cycles, back-to-back).
- If the output word is accepted and no new word is loaded, tvalid returns to 0 next cycle.
- FSM:
  - IDLE (idx=0, no bytes accumulated this packet) -> FILL on an accepted tstrb=1 non-closing byte.
  - FILL -> IDLE when a word closes with tlast=1.
  - FILL -> FILL when a full word closes without tlast.
- pkt_len/pkt_done:
  - The count is captured into a pending register when the tlast word is loaded.
  - pkt_len updates and pkt_done pulses for one cycle on the edge where that word is accepted downstream.
  - The running count resets to 0 for the next packet.
- Length saturates at 2^LEN_WIDTH-1; no wrap.

Optional Feature:
- PACKER_BIG_ENDIAN_EN defined: the first byte of each word goes to lane BYTES-1 (bits [DATA_WIDTH-1 -: 8]) and lanes fill downward. The strobe bit for lane BYTES-1 is set first, and a partial word occupies the top lanes.
- Undefined (default): little-endian; the first byte goes to lane 0 and lanes fill upward.
- Handshake, latency and length reporting are identical in both modes.

Test Plan:
- Reset, then 8 bytes 0x11..0x88 with tstrb=1, tlast on 0x88, m01_axis_tready=1 -> words 0x44332211 (tstrb 0xF, tlast 0) and 0x88776655 (tstrb 0xF, tlast 1); pkt_done pulses once; pkt_len=8.
- 6 bytes 0xA1..0xA6, tlast on 0xA6 -> 0xA4A3A2A1/0xF/0, then 0x0000A6A5/0x3/1; pkt_len=6.
- Stream 0x01,0x02 with tstrb=0 on 0x02, then 0x03,0x04,0x05 (tlast) -> one word 0x05040301/0xF/1; pkt_len=4.
- m01_axis_tready held 0 for 5 cycles after the first word -> word stable, s01_axis_tready=0; after release, a continuous stream yields back-to-back words with tvalid never dropping.
- Assert reset after 3 bytes of a packet, then send 0xB1..0xB4 (tlast) -> only 0xB4B3B2B1/0xF/1 is emitted; pkt_len=4.
- With PACKER_BIG_ENDIAN_EN, bytes 0x11,0x22,0x33 (tlast) -> 0x11223300, tstrb 0xE, tlast 1.
